unidade_de_busca: RTL and testbench

Instruction fetch unit sitting directly upstream of the instruction memory. It owns the program counter and drives the memory's word address. It registers the returned instruction, together with its PC, into a fetch register for the decoder. It also handles stall, branch/jump redirect, the `hlt` opcode and out-of-range fetches.

---
 rtl/unidade_de_busca.sv | 152 +++++++++++++++
 tb/tb_unidade_de_busca.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_de_busca.sv
// -----------------------------------------------------------------------------
// unidade_de_busca
//
// Instruction fetch unit sitting directly in front of the instruction memory.
// It owns the program counter, presents it to the memory as a word address and
// registers the returned instruction together with its PC for the decoder.
// Stall, branch/jump redirect, the hlt opcode and out-of-range fetches are
// handled here.
//
// Parameters:
//   PC_INICIAL    PC loaded at reset (program starts at word 1)
//   ENDERECO_MAX  highest valid instruction word index
//   OPCODE_HLT    opcode (instrucao[31:27]) that halts fetching
//
// Ports:
//   clock            in   single clock, rising edge
//   reset            in   asynchronous, active-low reset
//   instrucao        in   instruction word read combinationally at endereco
//   stall            in   hold request from downstream
//   desvio_valido    in   redirect request from execute
//   desvio_alvo      in   redirect target word address
//   endereco         out  current PC (memory word address)
//   instrucao_saida  out  fetch register: captured instruction
//   pc_saida         out  PC of instrucao_saida
//   valido           out  instrucao_saida is a live instruction
//   parado           out  unit is halted
//   erro             out  halt was caused by an out-of-range PC
// -----------------------------------------------------------------------------
module unidade_de_busca #(
    parameter logic [31:0] PC_INICIAL   = 32'd1,
    parameter logic [31:0] ENDERECO_MAX = 32'd20,
    parameter logic [4:0]  OPCODE_HLT   = 5'd18
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instrucao,
    input  logic        stall,
    input  logic        desvio_valido,
    input  logic [31:0] desvio_alvo,
    output logic [31:0] endereco,
    output logic [31:0] instrucao_saida,
    output logic [31:0] pc_saida,
    output logic        valido,
    output logic        parado,
    output logic        erro
);

    // INICIO gives the instruction memory its first edge to load the program
    // before anything is fetched.
    typedef enum logic [1:0] {
        INICIO,
        BUSCA,
        PARADO
    } estado_t;

    estado_t     estado_q, estado_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcSaida_q, pcSaida_d;
    logic        valido_q, valido_d;
    logic        parado_q, parado_d;
    logic        erro_q, erro_d;

    // State and datapath registers; reset is asynchronous and active low.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q  <= INICIO;
            pc_q      <= PC_INICIAL;
            instr_q   <= 32'd0;
            pcSaida_q <= 32'd0;
            valido_q  <= 1'b0;
            parado_q  <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pcSaida_q <= pcSaida_d;
            valido_q  <= valido_d;
            parado_q  <= parado_d;
            erro_q    <= erro_d;
        end
    end

    // Next-state logic. Everything holds by default; in BUSCA the redirect
    // outranks the stall, which outranks the range check, which outranks a
    // normal fetch.
    always_comb begin
        estado_d  = estado_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        pcSaida_d = pcSaida_q;
        valido_d  = valido_q;
        erro_d    = erro_q;

        case (estado_q)
            INICIO: begin
                estado_d = BUSCA;
            end

            BUSCA: begin
                if (desvio_valido) begin
                    // Squash: the word currently addressed is on the wrong path.
                    pc_d     = desvio_alvo;
                    valido_d = 1'b0;
                end else if (stall) begin
                    // Hold everything.
                end else if (pc_q > ENDERECO_MAX) begin
                    estado_d = PARADO;
                    erro_d   = 1'b1;
                    valido_d = 1'b0;
                end else begin
                    instr_d   = instrucao;
                    pcSaida_d = pc_q;
                    valido_d  = 1'b1;
                    if (instrucao[31:27] == OPCODE_HLT) begin
                        estado_d = PARADO;
                    end else begin
                        pc_d = pc_q + 32'd1;
                    end
                end
            end

            PARADO: begin
                // A late branch after a wrong-path hlt must be able to resume
                // fetch; while stalled, valido holds so the hlt is not lost.
                if (desvio_valido) begin
                    estado_d = BUSCA;
                    pc_d     = desvio_alvo;
                    erro_d   = 1'b0;
                    valido_d = 1'b0;
                end else if (!stall) begin
                    valido_d = 1'b0;
                end
            end

            default: begin
                estado_d = INICIO;
            end
        endcase
    end

    assign parado_d = (estado_d == PARADO);

    assign endereco        = pc_q;
    assign instrucao_saida = instr_q;
    assign pc_saida        = pcSaida_q;
    assign valido          = valido_q;
    assign parado          = parado_q;
    assign erro            = erro_q;

endmodule

// File: tb/tb_unidade_de_busca.sv
// -----------------------------------------------------------------------------
// tb_unidade_de_busca
//
// Bench for the fetch unit. A small instruction memory answers endereco
// combinationally. Whenever a fetch of word N is expected on the next edge,
// {N, mem[N]} is pushed to a scoreboard queue and popped after that edge to
// compare against pc_saida/instrucao_saida.
// -----------------------------------------------------------------------------
module tb_unidade_de_busca;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } esperado_t;

    logic        clock;
    logic        reset;
    logic [31:0] instrucao;
    logic        stall;
    logic        desvio_valido;
    logic [31:0] desvio_alvo;
    logic [31:0] endereco;
    logic [31:0] instrucao_saida;
    logic [31:0] pc_saida;
    logic        valido;
    logic        parado;
    logic        erro;

    logic [31:0] mem [0:31];
    esperado_t   scoreboard [$];
    esperado_t   esp;
    int          assertCount;
    int          failCount;

    unidade_de_busca dut (
        .clock           (clock),
        .reset           (reset),
        .instrucao       (instrucao),
        .stall           (stall),
        .desvio_valido   (desvio_valido),
        .desvio_alvo     (desvio_alvo),
        .endereco        (endereco),
        .instrucao_saida (instrucao_saida),
        .pc_saida        (pc_saida),
        .valido          (valido),
        .parado          (parado),
        .erro            (erro)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Instruction memory: combinational read, anything past the array reads a
    // non-hlt filler word.
    always_comb begin
        if (endereco < 32'd32) instrucao = mem[endereco[4:0]];
        else                   instrucao = 32'hDEADBEEF;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic dv, input logic [31:0] alvo);
        stall         = st;
        desvio_valido = dv;
        desvio_alvo   = alvo;
    endtask

    // Reset is pulsed between edges; the next edge performs INICIO -> BUSCA.
    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 32'd0);
        scoreboard.delete();
        reset = 1'b0;
        #3;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 32'd9);
        tick();
        assertCount++;
        if (endereco !== 32'd1 || instrucao_saida !== 32'd0 || pc_saida !== 32'd0 ||
            valido !== 1'b0 || parado !== 1'b0 || erro !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_values: got end=%0d ins=%h pc=%0d v=%b p=%b e=%b, expected 1/0/0/0/0/0",
                     endereco, instrucao_saida, pc_saida, valido, parado, erro);
        end
        doReset();
        tick();
        assertCount++;
        if (valido !== 1'b0 || endereco !== 32'd1) begin
            failCount++;
            $display("[TB] FAIL edge1: got valido=%b endereco=%0d, expected 0 and 1", valido, endereco);
        end
        tick();
        assertCount++;
        if (instrucao_saida !== 32'hC9000032 || pc_saida !== 32'd1 || valido !== 1'b1 || endereco !== 32'd2) begin
            failCount++;
            $display("[TB] FAIL edge2: got ins=%h pc=%0d v=%b end=%0d, expected C9000032/1/1/2",
                     instrucao_saida, pc_saida, valido, endereco);
        end
    endtask

    task automatic test_straight_line();
        $display("[TB] test_straight_line");
        doReset();
        tick();
        for (int k = 1; k <= 7; k++) begin
            assertCount++;
            if (endereco !== 32'(k)) begin
                failCount++;
                $display("[TB] FAIL line_endereco: got %0d expected %0d", endereco, k);
            end
            scoreboard.push_back('{pc: 32'(k), instr: mem[k]});
            tick();
            assertCount++;
            if (scoreboard.size() == 0) begin
                failCount++;
                $display("[TB] FAIL line_scoreboard: queue empty, expected an entry");
            end else begin
                esp = scoreboard.pop_front();
                if (pc_saida !== esp.pc || instrucao_saida !== esp.instr || valido !== 1'b1) begin
                    failCount++;
                    $display("[TB] FAIL line_fetch: got pc=%0d ins=%h v=%b expected pc=%0d ins=%h v=1",
                             pc_saida, instrucao_saida, valido, esp.pc, esp.instr);
                end
            end
        end
        assertCount++;
        if (parado !== 1'b1 || endereco !== 32'd7 || valido !== 1'b1 || erro !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL hlt_capture: got p=%b end=%0d v=%b e=%b expected 1/7/1/0",
                     parado, endereco, valido, erro);
        end
        // Stalled while halted: valido must hold so the hlt is not lost.
        applyStimulus(1'b1, 1'b0, 32'd0);
        tick();
        assertCount++;
        if (valido !== 1'b1 || parado !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL hlt_stall: got v=%b p=%b expected 1/1", valido, parado);
        end
        applyStimulus(1'b0, 1'b0, 32'd0);
        tick();
        assertCount++;
        if (valido !== 1'b0 || parado !== 1'b1 || endereco !== 32'd7 || pc_saida !== 32'd7) begin
            failCount++;
            $display("[TB] FAIL hlt_after: got v=%b p=%b end=%0d pc=%0d expected 0/1/7/7",
                     valido, parado, endereco, pc_saida);
        end
    endtask

    task automatic test_stall();
        $display("[TB] test_stall");
        doReset();
        repeat (3) tick();
        applyStimulus(1'b1, 1'b0, 32'd0);
        for (int c = 0; c < 2; c++) begin
            tick();
            assertCount++;
            if (pc_saida !== 32'd2 || valido !== 1'b1 || endereco !== 32'd3) begin
                failCount++;
                $display("[TB] FAIL stall_hold: got pc=%0d v=%b end=%0d expected 2/1/3",
                         pc_saida, valido, endereco);
            end
        end
        applyStimulus(1'b0, 1'b0, 32'd0);
        scoreboard.push_back('{pc: 32'd3, instr: mem[3]});
        tick();
        assertCount++;
        if (scoreboard.size() == 0) begin
            failCount++;
            $display("[TB] FAIL stall_scoreboard: queue empty, expected an entry");
        end else begin
            esp = scoreboard.pop_front();
            if (pc_saida !== esp.pc || instrucao_saida !== esp.instr || valido !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL stall_release: got pc=%0d ins=%h v=%b expected pc=%0d ins=%h v=1",
                         pc_saida, instrucao_saida, valido, esp.pc, esp.instr);
            end
        end
    endtask

    task automatic test_redirect_stall();
        $display("[TB] test_redirect_stall");
        doReset();
        repeat (3) tick();
        applyStimulus(1'b1, 1'b1, 32'd5);
        tick();
        assertCount++;
        if (valido !== 1'b0 || endereco !== 32'd5 || pc_saida !== 32'd2) begin
            failCount++;
            $display("[TB] FAIL redirect_squash: got v=%b end=%0d pc=%0d expected 0/5/2",
                     valido, endereco, pc_saida);
        end
        applyStimulus(1'b0, 1'b0, 32'd0);
        scoreboard.push_back('{pc: 32'd5, instr: mem[5]});
        tick();
        assertCount++;
        if (scoreboard.size() == 0) begin
            failCount++;
            $display("[TB] FAIL redirect_scoreboard: queue empty, expected an entry");
        end else begin
            esp = scoreboard.pop_front();
            if (pc_saida !== esp.pc || instrucao_saida !== esp.instr || valido !== 1'b1 || endereco !== 32'd6) begin
                failCount++;
                $display("[TB] FAIL redirect_target: got pc=%0d ins=%h v=%b end=%0d expected pc=%0d ins=%h v=1 end=6",
                         pc_saida, instrucao_saida, valido, endereco, esp.pc, esp.instr);
            end
        end
    endtask

    task automatic test_out_of_range();
        $display("[TB] test_out_of_range");
        doReset();
        repeat (3) tick();
        // Last valid word, then natural step past the end.
        applyStimulus(1'b0, 1'b1, 32'd20);
        tick();
        assertCount++;
        if (endereco !== 32'd20 || valido !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL range_to20: got end=%0d v=%b expected 20/0", endereco, valido);
        end
        applyStimulus(1'b0, 1'b0, 32'd0);
        scoreboard.push_back('{pc: 32'd20, instr: mem[20]});
        tick();
        assertCount++;
        if (scoreboard.size() == 0) begin
            failCount++;
            $display("[TB] FAIL range_scoreboard: queue empty, expected an entry");
        end else begin
            esp = scoreboard.pop_front();
            if (pc_saida !== esp.pc || instrucao_saida !== esp.instr || valido !== 1'b1 ||
                endereco !== 32'd21 || parado !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL range_word20: got pc=%0d ins=%h v=%b end=%0d p=%b expected pc=%0d ins=%h v=1 end=21 p=0",
                         pc_saida, instrucao_saida, valido, endereco, parado, esp.pc, esp.instr);
            end
        end
        // A stalled edge must not run the range check.
        applyStimulus(1'b1, 1'b0, 32'd0);
        tick();
        assertCount++;
        if (parado !== 1'b0 || endereco !== 32'd21 || valido !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL range_stalled: got p=%b end=%0d v=%b expected 0/21/1", parado, endereco, valido);
        end
        applyStimulus(1'b0, 1'b0, 32'd0);
        tick();
        assertCount++;
        if (parado !== 1'b1 || erro !== 1'b1 || valido !== 1'b0 || endereco !== 32'd21) begin
            failCount++;
            $display("[TB] FAIL range_halt: got p=%b e=%b v=%b end=%0d expected 1/1/0/21",
                     parado, erro, valido, endereco);
        end
        // Explicit redirect to 21 from PARADO.
        applyStimulus(1'b0, 1'b1, 32'd21);
        tick();
        assertCount++;
        if (endereco !== 32'd21 || parado !== 1'b0 || erro !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL range_to21: got end=%0d p=%b e=%b expected 21/0/0", endereco, parado, erro);
        end
        applyStimulus(1'b0, 1'b0, 32'd0);
        tick();
        assertCount++;
        if (parado !== 1'b1 || erro !== 1'b1 || valido !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL range_halt21: got p=%b e=%b v=%b expected 1/1/0", parado, erro, valido);
        end
        applyStimulus(1'b0, 1'b1, 32'd1);
        tick();
        assertCount++;
        if (parado !== 1'b0 || erro !== 1'b0 || endereco !== 32'd1 || valido !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL range_resume: got p=%b e=%b end=%0d v=%b expected 0/0/1/0",
                     parado, erro, endereco, valido);
        end
        applyStimulus(1'b0, 1'b0, 32'd0);
        scoreboard.push_back('{pc: 32'd1, instr: mem[1]});
        tick();
        assertCount++;
        if (scoreboard.size() == 0) begin
            failCount++;
            $display("[TB] FAIL resume_scoreboard: queue empty, expected an entry");
        end else begin
            esp = scoreboard.pop_front();
            if (pc_saida !== esp.pc || instrucao_saida !== esp.instr || valido !== 1'b1 || endereco !== 32'd2) begin
                failCount++;
                $display("[TB] FAIL resume_fetch: got pc=%0d ins=%h v=%b end=%0d expected pc=%0d ins=%h v=1 end=2",
                         pc_saida, instrucao_saida, valido, endereco, esp.pc, esp.instr);
            end
        end
    endtask

    task automatic test_async_reset();
        $display("[TB] test_async_reset");
        doReset();
        repeat (5) tick();
        assertCount++;
        if (pc_saida !== 32'd4 || valido !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL async_setup: got pc=%0d v=%b expected 4/1", pc_saida, valido);
        end
        #2;
        reset = 1'b0;
        #1;
        assertCount++;
        if (endereco !== 32'd1 || instrucao_saida !== 32'd0 || pc_saida !== 32'd0 ||
            valido !== 1'b0 || parado !== 1'b0 || erro !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL async_reset: got end=%0d ins=%h pc=%0d v=%b p=%b e=%b, expected 1/0/0/0/0/0",
                     endereco, instrucao_saida, pc_saida, valido, parado, erro);
        end
        reset = 1'b1;
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        reset       = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 32; i++) begin
            mem[i] = {5'd1, 27'(i * 3 + 100)};
        end
        mem[1] = 32'hC9000032;
        mem[7] = {5'd18, 27'h7};

        test_reset();
        test_straight_line();
        test_stall();
        test_redirect_stall();
        test_out_of_range();
        test_async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
